pll_lock_sequencer: RTL and testbench

Sequences the audio PLL (50 MHz refclk in, 12.288 MHz audio clock out) from power-up and after any lock loss. It drives the PLL reset, debounces the asynchronous locked flag, and holds the audio-domain reset until lock has been stable. It retries the PLL a bounded number of times, then reports a fault. It runs entirely in the refclk domain; audio-domain consumers re-synchronise audio_rst_n locally.

---
 rtl/pll_lock_sequencer_pkg.sv | 40 ++++
 rtl/pll_lock_sequencer_sync_2ff.sv | 26 ++
 rtl/pll_lock_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and constants for the audio PLL lock sequencer.
// Holds the state encoding, default tuning constants and the timer width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 50000;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES    = 3;
    localparam int DEF_CNT_W          = 8;

    // The shared timer only ever counts up to (longest interval - 1).
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        if (m < 2) begin
            return 1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser, async active-low reset to 0.
// Generic CDC building block; nothing here is specific to the PLL sequencer.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Audio PLL power-up / relock sequencer, refclk domain only.
// Optional saturating lock-loss counter is built when PLL_LOSS_COUNTER_EN is defined.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               retry_req,
    output logic                               pll_rst,
    output logic                               audio_rst_n,
    output logic                               ready,
    output logic                               fault,
    output logic [2:0]                         state_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [CNT_W-1:0]                   loss_cnt
);

    localparam int TMR_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RC_W  = $clog2(MAX_RETRIES + 1);

    logic             locked_s;
    pll_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RC_W-1:0]  retry_cnt_q, retry_cnt_d;
    logic [RC_W-1:0]  retry_inc_s;
    logic             pll_rst_q, pll_rst_d;
    logic             audio_rst_n_q, audio_rst_n_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    assign retry_inc_s = retry_cnt_q + RC_W'(1);

    // Next-state, shared timer and retry bookkeeping; outputs follow the next state.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        retry_cnt_d   = retry_cnt_q;
        case (state_q)
            RESET_PLL: begin
                if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    timer_d = {TMR_W{1'b0}};
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABILIZE;
                    timer_d = {TMR_W{1'b0}};
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    retry_cnt_d = retry_inc_s;
                    timer_d     = {TMR_W{1'b0}};
                    if (retry_inc_s == RC_W'(MAX_RETRIES)) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RESET_PLL;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            STABILIZE: begin
                // Any dropout restarts the lock wait but does not count as a failed attempt.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = {TMR_W{1'b0}};
                end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                    state_d     = RUN;
                    timer_d     = {TMR_W{1'b0}};
                    retry_cnt_d = {RC_W{1'b0}};
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            RUN: begin
                timer_d = {TMR_W{1'b0}};
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                timer_d = {TMR_W{1'b0}};
                if (retry_req) begin
                    state_d     = RESET_PLL;
                    retry_cnt_d = {RC_W{1'b0}};
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d     = RESET_PLL;
                timer_d     = {TMR_W{1'b0}};
                retry_cnt_d = {RC_W{1'b0}};
            end
        endcase

        pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAULT);
        audio_rst_n_d = (state_d == RUN);
        ready_d       = (state_d == RUN);
        fault_d       = (state_d == FAULT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_PLL;
            timer_q       <= {TMR_W{1'b0}};
            retry_cnt_q   <= {RC_W{1'b0}};
            pll_rst_q     <= 1'b1;
            audio_rst_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            retry_cnt_q   <= retry_cnt_d;
            pll_rst_q     <= pll_rst_d;
            audio_rst_n_q <= audio_rst_n_d;
            ready_q       <= ready_d;
            fault_q       <= fault_d;
        end
    end

`ifdef PLL_LOSS_COUNTER_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // A lock loss is a RUN cycle that sees the synchronised flag low; count saturates.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == RUN) && !locked_s && (loss_cnt_q != {CNT_W{1'b1}})) begin
            loss_cnt_d = loss_cnt_q + CNT_W'(1);
        end else begin
            loss_cnt_d = loss_cnt_q;
        end
    end

    // Lock-loss counter register, cleared only by rst_n.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = {CNT_W{1'b0}};
`endif

    assign pll_rst     = pll_rst_q;
    assign audio_rst_n = audio_rst_n_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign state_o     = state_q;
    assign retry_cnt   = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed scoreboard bench for pll_lock_sequencer with short timing parameters.
// Expected loss_cnt depends on whether PLL_LOSS_COUNTER_EN is defined for the build.
module tb_pll_lock_sequencer;

    localparam int PRC = 4;
    localparam int LTO = 20;
    localparam int STC = 8;
    localparam int MR  = 2;
    localparam int CW  = 8;
    localparam int RCW = $clog2(MR + 1);

    logic           refclk = 1'b0;
    logic           rst_n;
    logic           pll_locked;
    logic           retry_req;
    logic           pll_rst;
    logic           audio_rst_n;
    logic           ready;
    logic           fault;
    logic [2:0]     state_o;
    logic [RCW-1:0] retry_cnt;
    logic [CW-1:0]  loss_cnt;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LTO),
        .STABLE_CYCLES  (STC),
        .MAX_RETRIES    (MR),
        .CNT_W          (CW)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .retry_req   (retry_req),
        .pll_rst     (pll_rst),
        .audio_rst_n (audio_rst_n),
        .ready       (ready),
        .fault       (fault),
        .state_o     (state_o),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_loss;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $error("FAIL sb_empty observed=%0h expected=queued_entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    function automatic int sat_inc(input int v);
`ifdef PLL_LOSS_COUNTER_EN
        if (v < (1 << CW) - 1) return v + 1;
        else return v;
`else
        return v * 0;
`endif
    endfunction

    task automatic check_reset(input string where);
        push({where, "_pll_rst"}, 32'd1);
        push({where, "_audio_rst_n"}, 32'd0);
        push({where, "_ready"}, 32'd0);
        push({where, "_fault"}, 32'd0);
        push({where, "_state"}, 32'd0);
        push({where, "_retry_cnt"}, 32'd0);
        push({where, "_loss_cnt"}, 32'd0);
        chk(pll_rst);
        chk(audio_rst_n);
        chk(ready);
        chk(fault);
        chk(state_o);
        chk(retry_cnt);
        chk(loss_cnt);
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        push("wait_ready", 32'd1);
        chk(ready);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        retry_req  = 1'b0;
        exp_loss   = 0;
        tick(3);
        check_reset("por");

        // Power-up: 4-cycle pll_rst, then lock -> ready after 11 cycles.
        rst_n = 1'b1;
        for (int k = 1; k <= PRC; k++) begin
            push("por_pll_rst", (k < PRC) ? 32'd1 : 32'd0);
            tick(1);
            chk(pll_rst);
        end
        push("por_state_wait", 32'd1);
        chk(state_o);
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            push("lock_ready", (k >= 11) ? 32'd1 : 32'd0);
            push("lock_audio_rst_n", (k >= 11) ? 32'd1 : 32'd0);
            tick(1);
            chk(ready);
            chk(audio_rst_n);
        end
        push("lock_retry_cnt", 32'd0);
        push("lock_state_run", 32'd3);
        push("lock_pll_rst", 32'd0);
        chk(retry_cnt);
        chk(state_o);
        chk(pll_rst);

        // retry_req is ignored in RUN.
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        push("run_retry_ignored_state", 32'd3);
        chk(state_o);

        // Lock loss in RUN.
        pll_locked = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            push("loss_ready", (k < 3) ? 32'd1 : 32'd0);
            push("loss_audio_rst_n", (k < 3) ? 32'd1 : 32'd0);
            tick(1);
            chk(ready);
            chk(audio_rst_n);
        end
        exp_loss = sat_inc(exp_loss);
        push("loss_cnt_first", exp_loss);
        push("loss_state_wait", 32'd1);
        push("loss_pll_rst", 32'd0);
        chk(loss_cnt);
        chk(state_o);
        chk(pll_rst);
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            push("relock_ready", (k >= 11) ? 32'd1 : 32'd0);
            tick(1);
            chk(ready);
        end

        // One failed attempt, then a glitch during STABILIZE.
        pll_locked = 1'b0;
        tick(3);
        exp_loss = sat_inc(exp_loss);
        push("g_loss_cnt", exp_loss);
        chk(loss_cnt);
        tick(LTO - 1);
        push("g_before_timeout", 32'd1);
        chk(state_o);
        tick(1);
        push("g_timeout_state", 32'd0);
        push("g_timeout_retry", 32'd1);
        push("g_timeout_pll_rst", 32'd1);
        chk(state_o);
        chk(retry_cnt);
        chk(pll_rst);
        tick(PRC);
        push("g_wait_pll_rst", 32'd0);
        chk(pll_rst);
        pll_locked = 1'b1;
        tick(5);
        push("g_in_stabilize", 32'd2);
        chk(state_o);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            push("g_pll_rst", 32'd0);
            push("g_ready", (k >= 11) ? 32'd1 : 32'd0);
            if (k == 2) push("g_back_to_wait", 32'd1);
            if (k == 10) push("g_retry_kept", 32'd1);
            if (k == 11) push("g_retry_cleared", 32'd0);
            tick(1);
            chk(pll_rst);
            chk(ready);
            if (k == 2) chk(state_o);
            if (k == 10 || k == 11) chk(retry_cnt);
        end

        // Lock held off: two timeouts lead to FAULT.
        pll_locked = 1'b0;
        tick(3);
        exp_loss = sat_inc(exp_loss);
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        push("f_retry_ignored_wait", 32'd1);
        push("f_no_fault", 32'd0);
        chk(state_o);
        chk(fault);
        tick(LTO - 1);
        push("f_first_timeout", 32'd0);
        push("f_first_retry", 32'd1);
        chk(state_o);
        chk(retry_cnt);
        for (int k = 1; k <= PRC; k++) begin
            push("f_pulse1_pll_rst", (k < PRC) ? 32'd1 : 32'd0);
            tick(1);
            chk(pll_rst);
        end
        tick(LTO - 1);
        push("f_wait_before_fault", 32'd1);
        chk(state_o);
        tick(1);
        push("f_fault", 32'd1);
        push("f_state", 32'd4);
        push("f_pll_rst", 32'd1);
        push("f_retry_cnt", 32'd2);
        push("f_ready", 32'd0);
        push("f_audio_rst_n", 32'd0);
        chk(fault);
        chk(state_o);
        chk(pll_rst);
        chk(retry_cnt);
        chk(ready);
        chk(audio_rst_n);
        tick(5);
        push("f_stays_fault", 32'd4);
        chk(state_o);
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        push("f_retry_state", 32'd0);
        push("f_retry_fault", 32'd0);
        push("f_retry_cnt_clr", 32'd0);
        chk(state_o);
        chk(fault);
        chk(retry_cnt);
        for (int k = 1; k <= PRC; k++) begin
            push("f_new_pulse_pll_rst", (k < PRC) ? 32'd1 : 32'd0);
            tick(1);
            chk(pll_rst);
        end

        // Async reset in the middle of FAULT.
        tick(LTO + PRC + LTO);
        push("fr_in_fault", 32'd4);
        chk(state_o);
        #3;
        rst_n = 1'b0;
        #1;
        exp_loss = 0;
        check_reset("fault_async_rst");
        tick(1);
        rst_n = 1'b1;

        // Async reset in the middle of STABILIZE.
        pll_locked = 1'b1;
        tick(PRC + 3);
        push("sr_in_stabilize", 32'd2);
        chk(state_o);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("stab_async_rst");
        tick(1);
        rst_n = 1'b1;
        wait_ready(40);

        // Repeated lock loss: saturation (or constant 0 without the counter).
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            tick(3);
            pll_locked = 1'b1;
            tick(11);
            exp_loss = sat_inc(exp_loss);
            if (i == 0 || i == 254 || i == 299) begin
                push("sat_loss_cnt", exp_loss);
                chk(loss_cnt);
            end
        end
`ifdef PLL_LOSS_COUNTER_EN
        push("sat_final_loss_cnt", 32'd255);
`else
        push("sat_final_loss_cnt", 32'd0);
`endif
        push("sat_final_ready", 32'd1);
        chk(loss_cnt);
        chk(ready);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
